// File: rtl/dmem_resp_queue.sv
// In-order tracker pairing dmem response beats with outstanding load/store requests for writeback.
// Define DMEM_RESP_RAW_EN to add the wb_raw_rdata and wb_outstanding outputs.
module dmem_resp_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_is_load,
    input  logic [2:0]                    req_funct3,
    input  logic [$clog2(DATA_W/8)-1:0]   req_addr_lo,
    input  logic [4:0]                    req_rd_addr,
    input  logic                          req_regf_we,
    input  logic                          dmem_resp,
    input  logic [DATA_W-1:0]             dmem_rdata,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic                          wb_regf_we,
    output logic [4:0]                    wb_rd_addr,
    output logic [DATA_W-1:0]             wb_data,
    output logic                          busy,
    output logic                          resp_err
`ifdef DMEM_RESP_RAW_EN
    ,
    output logic [DATA_W-1:0]             wb_raw_rdata,
    output logic [$clog2(DEPTH):0]        wb_outstanding
`endif
);

    localparam int OFF_W = $clog2(DATA_W/8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic              is_load;
        logic [2:0]        funct3;
        logic [OFF_W-1:0]  addr_lo;
        logic [4:0]        rd;
        logic              regf_we;
        logic [DATA_W-1:0] data;
        logic              done;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] resp_ptr_q, resp_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             resp_err_q, resp_err_d;

    logic             full;
    logic             push;
    logic             resp_hit;
    logic             pop;
    entry_t           head;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;
    logic [DATA_W-1:0] ext;
    logic             load_ok;

    always_comb begin
        full     = (PTR_W'(wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH));
        head     = mem_q[rd_ptr_q[IDX_W-1:0]];
        wb_valid = head.done && (rd_ptr_q != wr_ptr_q);
        push     = req_valid && !full;
        resp_hit = dmem_resp && (resp_ptr_q != wr_ptr_q);
        pop      = wb_valid && wb_ready;
    end

    // Pop, response and enqueue always target distinct slots, so their order here is immaterial.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        resp_ptr_d = resp_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        resp_err_d = resp_err_q;
        if (pop) begin
            mem_d[rd_ptr_q[IDX_W-1:0]].done = 1'b0;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (resp_hit) begin
            mem_d[resp_ptr_q[IDX_W-1:0]].data = dmem_rdata;
            mem_d[resp_ptr_q[IDX_W-1:0]].done = 1'b1;
            resp_ptr_d = resp_ptr_q + PTR_W'(1);
        end else if (dmem_resp) begin
            resp_err_d = 1'b1;
        end
        if (push) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = '{
                is_load: req_is_load,
                funct3:  req_funct3,
                addr_lo: req_addr_lo,
                rd:      req_rd_addr,
                regf_we: req_regf_we,
                data:    '0,
                done:    1'b0
            };
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            resp_ptr_q <= '0;
            rd_ptr_q   <= '0;
            resp_err_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            resp_ptr_q <= resp_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            resp_err_q <= resp_err_d;
            mem_q      <= mem_d;
        end
    end

    // Lane selection from the head byte offset; halves and words ignore the low offset bits.
    always_comb begin
        byte_v = 8'(head.data >> {head.addr_lo, 3'b000});
        half_v = 16'(head.data >> {head.addr_lo[OFF_W-1:1], 4'b0000});
        if (DATA_W == 64) begin
            word_v = 32'(head.data >> {head.addr_lo[OFF_W-1], 5'b00000});
        end else begin
            word_v = head.data[31:0];
        end
        ext     = '0;
        load_ok = 1'b1;
        case (head.funct3)
            3'b000:  ext = DATA_W'($signed(byte_v));
            3'b100:  ext = DATA_W'(byte_v);
            3'b001:  ext = DATA_W'($signed(half_v));
            3'b101:  ext = DATA_W'(half_v);
            3'b010:  ext = DATA_W'($signed(word_v));
            3'b110: begin
                if (DATA_W == 64) ext = DATA_W'(word_v);
                else              load_ok = 1'b0;
            end
            3'b011: begin
                if (DATA_W == 64) ext = head.data;
                else              load_ok = 1'b0;
            end
            default: load_ok = 1'b0;
        endcase
    end

    always_comb begin
        req_ready  = !full;
        busy       = (wr_ptr_q != rd_ptr_q);
        resp_err   = resp_err_q;
        wb_regf_we = wb_valid && head.is_load && head.regf_we && load_ok;
        wb_rd_addr = wb_valid ? head.rd : '0;
        wb_data    = (wb_valid && head.is_load && load_ok) ? ext : '0;
    end

`ifdef DMEM_RESP_RAW_EN
    always_comb begin
        wb_raw_rdata   = wb_valid ? head.data : '0;
        wb_outstanding = PTR_W'(wr_ptr_q - rd_ptr_q);
    end
`endif

endmodule

// File: tb/tb_dmem_resp_queue.sv
// Self-checking bench for dmem_resp_queue: queue-based reference model, directed cases, random traffic.
module tb_dmem_resp_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int OW    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid, req_ready, req_is_load, req_regf_we;
    logic [2:0]    req_funct3;
    logic [OW-1:0] req_addr_lo;
    logic [4:0]    req_rd_addr;
    logic          dmem_resp;
    logic [DW-1:0] dmem_rdata;
    logic          wb_valid, wb_ready, wb_regf_we, busy, resp_err;
    logic [4:0]    wb_rd_addr;
    logic [DW-1:0] wb_data;

    logic          q_valid, q_ready, q_is_load, q_we, q_resp;
    logic [2:0]    q_funct3;
    logic [2:0]    q_addr_lo;
    logic [4:0]    q_rd;
    logic [63:0]   q_rdata;
    logic          q_wb_valid, q_wb_ready, q_wb_regf_we, q_busy, q_resp_err;
    logic [4:0]    q_wb_rd;
    logic [63:0]   q_wb_data;
`ifdef DMEM_RESP_RAW_EN
    logic [DW-1:0] wb_raw_rdata;
    logic [2:0]    wb_outstanding;
    logic [63:0]   q_raw;
    logic [2:0]    q_outstanding;
`endif

    dmem_resp_queue #(.DATA_W(DW), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
        .req_funct3(req_funct3), .req_addr_lo(req_addr_lo), .req_rd_addr(req_rd_addr),
        .req_regf_we(req_regf_we), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_regf_we(wb_regf_we),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .busy(busy), .resp_err(resp_err)
`ifdef DMEM_RESP_RAW_EN
        , .wb_raw_rdata(wb_raw_rdata), .wb_outstanding(wb_outstanding)
`endif
    );

    dmem_resp_queue #(.DATA_W(64), .DEPTH(4)) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(q_valid), .req_ready(q_ready), .req_is_load(q_is_load),
        .req_funct3(q_funct3), .req_addr_lo(q_addr_lo), .req_rd_addr(q_rd),
        .req_regf_we(q_we), .dmem_resp(q_resp), .dmem_rdata(q_rdata),
        .wb_valid(q_wb_valid), .wb_ready(q_wb_ready), .wb_regf_we(q_wb_regf_we),
        .wb_rd_addr(q_wb_rd), .wb_data(q_wb_data), .busy(q_busy), .resp_err(q_resp_err)
`ifdef DMEM_RESP_RAW_EN
        , .wb_raw_rdata(q_raw), .wb_outstanding(q_outstanding)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: allocated requests in order; the first `answered` of them hold response data.
    typedef struct {
        bit              is_load;
        bit [2:0]        f3;
        int              off;
        bit [4:0]        rd;
        bit              we;
        longint unsigned data;
    } ent_t;

    ent_t mq[$];
    int   answered = 0;
    bit   merr = 1'b0;
    bit   started = 1'b0;

    function automatic bit m_ok(input bit [2:0] f3);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic longint unsigned m_ext(input ent_t e);
        longint unsigned v;
        if (!e.is_load) return 0;
        case (e.f3)
            3'd0, 3'd4: begin
                v = (e.data >> (e.off * 8)) & 64'hFF;
                if (e.f3 == 3'd0 && v >= 64'h80) v = v - 64'h100;
            end
            3'd1, 3'd5: begin
                v = (e.data >> ((e.off / 2) * 16)) & 64'hFFFF;
                if (e.f3 == 3'd1 && v >= 64'h8000) v = v - 64'h10000;
            end
            3'd2: begin
                v = e.data & 64'hFFFF_FFFF;
                if (v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
            end
            default: v = 0;
        endcase
        return v & 64'hFFFF_FFFF;
    endfunction

    initial begin
        bit pop_now;
        ent_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                answered = 0;
                merr = 1'b0;
            end else begin
                pop_now = (answered > 0) && wb_ready;
                if (dmem_resp) begin
                    if (answered < mq.size()) begin
                        mq[answered].data = longint'(dmem_rdata);
                        answered++;
                    end else begin
                        merr = 1'b1;
                    end
                end
                if (req_valid && mq.size() < DEPTH) begin
                    e.is_load = req_is_load;
                    e.f3      = req_funct3;
                    e.off     = int'(req_addr_lo);
                    e.rd      = req_rd_addr;
                    e.we      = req_regf_we;
                    e.data    = 0;
                    mq.push_back(e);
                end
                if (pop_now) begin
                    void'(mq.pop_front());
                    answered--;
                end
            end
            started = 1'b1;
        end
    end

    initial begin
        ent_t h;
        wait (started);
        forever begin
            @(negedge clk);
            chk("req_ready", req_ready, mq.size() < DEPTH);
            chk("busy", busy, mq.size() > 0);
            chk("resp_err", resp_err, merr);
            chk("wb_valid", wb_valid, answered > 0);
`ifdef DMEM_RESP_RAW_EN
            chk("wb_outstanding", wb_outstanding, mq.size());
`endif
            if (answered > 0) begin
                h = mq[0];
                chk("wb_rd_addr", wb_rd_addr, h.rd);
                chk("wb_regf_we", wb_regf_we, h.is_load && h.we && m_ok(h.f3));
                chk("wb_data", wb_data, m_ext(h));
`ifdef DMEM_RESP_RAW_EN
                chk("wb_raw_rdata", wb_raw_rdata, h.data);
`endif
            end
        end
    end

    task automatic cyc(input bit rv, input bit ld, input bit [2:0] f3, input int off,
                       input bit [4:0] rd, input bit we, input bit rs,
                       input logic [31:0] rdat, input bit wr);
        req_valid   = rv;
        req_is_load = ld;
        req_funct3  = f3;
        req_addr_lo = OW'(off);
        req_rd_addr = rd;
        req_regf_we = we;
        dmem_resp   = rs;
        dmem_rdata  = rdat;
        wb_ready    = wr;
        @(negedge clk);
    endtask

    task automatic cyc64(input bit rv, input bit [2:0] f3, input int off, input bit rs,
                         input logic [63:0] rdat);
        q_valid    = rv;
        q_is_load  = 1'b1;
        q_funct3   = f3;
        q_addr_lo  = 3'(off);
        q_rd       = 5'd12;
        q_we       = 1'b1;
        q_resp     = rs;
        q_rdata    = rdat;
        q_wb_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit rv, rs;
        rst = 1'b1;
        req_valid = 0; req_is_load = 0; req_funct3 = 0; req_addr_lo = 0; req_rd_addr = 0;
        req_regf_we = 0; dmem_resp = 0; dmem_rdata = 0; wb_ready = 1;
        q_valid = 0; q_is_load = 0; q_funct3 = 0; q_addr_lo = 0; q_rd = 0;
        q_we = 0; q_resp = 0; q_rdata = 0; q_wb_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_regf_we", wb_regf_we, 0);
        chk("rst_wb_rd_addr", wb_rd_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_err", resp_err, 0);
        rst = 1'b0;

        // lw rd=5, response one cycle later
        cyc(1, 1, 3'd2, 0, 5'd5, 1, 0, 32'h0, 1);
        chk("lw_not_yet_valid", wb_valid, 0);
        cyc(0, 0, 3'd0, 0, 5'd0, 0, 1, 32'hDEADBEEF, 1);
        chk("lw_valid", wb_valid, 1);
        chk("lw_rd", wb_rd_addr, 5);
        chk("lw_data", wb_data, 32'hDEADBEEF);
        chk("lw_we", wb_regf_we, 1);
        cyc(0, 0, 3'd0, 0, 5'd0, 0, 0, 32'h0, 1);
        chk("lw_busy_after_pop", busy, 0);

        // lb off=3 and lhu off=2
        cyc(1, 1, 3'd0, 3, 5'd7, 1, 0, 32'h0, 1);
        cyc(0, 0, 3'd0, 0, 5'd0, 0, 1, 32'h80123456, 1);
        chk("lb_data", wb_data, 32'hFFFFFF80);
        cyc(1, 1, 3'd5, 2, 5'd8, 1, 0, 32'h0, 1);
        cyc(0, 0, 3'd0, 0, 5'd0, 0, 1, 32'hBEEF1234, 1);
        chk("lhu_data", wb_data, 32'h0000BEEF);
        cyc(0, 0, 3'd0, 0, 5'd0, 0, 0, 32'h0, 1);

        // fill with wb stalled, then drain in order
        for (int i = 1; i <= 4; i++) cyc(1, 1, 3'd2, 0, 5'(i), 1, 0, 32'h0, 0);
        chk("full_req_ready", req_ready, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 0, 3'd0, 0, 5'd0, 0, 1, 32'(i), 0);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", wb_valid, 1);
            chk("drain_data", wb_data, 32'(i));
            chk("drain_rd", wb_rd_addr, 5'(i));
            chk("drain_busy", busy, 1);
            cyc(0, 0, 3'd0, 0, 5'd0, 0, 0, 32'h0, 1);
        end
        chk("drain_busy_end", busy, 0);

        // store then load; response for the store lands in the load's enqueue cycle
        cyc(1, 0, 3'd2, 0, 5'd9, 1, 0, 32'h0, 0);
        cyc(1, 1, 3'd2, 0, 5'd10, 1, 1, 32'h11111111, 0);
        cyc(0, 0, 3'd0, 0, 5'd0, 0, 1, 32'h22222222, 0);
        chk("st_valid", wb_valid, 1);
        chk("st_we", wb_regf_we, 0);
        chk("st_data", wb_data, 0);
        cyc(0, 0, 3'd0, 0, 5'd0, 0, 0, 32'h0, 1);
        chk("ld_after_st_data", wb_data, 32'h22222222);
        chk("ld_after_st_rd", wb_rd_addr, 10);
        chk("ld_after_st_we", wb_regf_we, 1);
        cyc(0, 0, 3'd0, 0, 5'd0, 0, 0, 32'h0, 1);

        // spurious response, sticky error, reset mid-queue
        cyc(0, 0, 3'd0, 0, 5'd0, 0, 1, 32'h5, 1);
        chk("spurious_err", resp_err, 1);
        cyc(1, 1, 3'd2, 0, 5'd3, 1, 0, 32'h0, 0);
        cyc(1, 1, 3'd2, 0, 5'd4, 1, 1, 32'h7, 0);
        chk("err_sticky", resp_err, 1);
        chk("two_busy", busy, 1);
        rst = 1'b1;
        cyc(0, 0, 3'd0, 0, 5'd0, 0, 0, 32'h0, 0);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", wb_valid, 0);
        chk("midrst_err", resp_err, 0);
        cyc(0, 0, 3'd0, 0, 5'd0, 0, 1, 32'h9, 1);
        chk("post_rst_resp_err", resp_err, 1);
        rst = 1'b1;
        cyc(0, 0, 3'd0, 0, 5'd0, 0, 0, 32'h0, 1);
        rst = 1'b0;

        // 64-bit instance: ld, lwu, lw at offset 4
        cyc64(1, 3'd3, 0, 0, 64'h0);
        cyc64(0, 3'd0, 0, 1, 64'h8000_0000_0000_0001);
        chk("ld64_valid", q_wb_valid, 1);
        chk("ld64_data", q_wb_data, 64'h8000_0000_0000_0001);
        cyc64(1, 3'd6, 4, 0, 64'h0);
        cyc64(0, 3'd0, 0, 1, 64'h8000_0000_1234_5678);
        chk("lwu64_data", q_wb_data, 64'h0000_0000_8000_0000);
        cyc64(1, 3'd2, 4, 0, 64'h0);
        cyc64(0, 3'd0, 0, 1, 64'h8000_0000_1234_5678);
        chk("lw64_data", q_wb_data, 64'hFFFF_FFFF_8000_0000);
        chk("lw64_we", q_wb_regf_we, 1);
        cyc64(0, 3'd0, 0, 0, 64'h0);
        chk("q64_busy", q_busy, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                cyc(0, 0, 3'd0, 0, 5'd0, 0, 0, 32'h0, 1);
                rst = 1'b0;
                continue;
            end
            rv = ($urandom_range(0, 2) != 0) && (mq.size() < DEPTH);
            rs = (mq.size() > answered) && ($urandom_range(0, 1) == 1);
            cyc(rv, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 3),
                5'($urandom), $urandom_range(0, 1) == 1, rs, $urandom, $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
